// File: rtl/redmule_pkg.sv
// Shared types and default array geometry for the RedMulE X-operand loader.
package redmule_pkg;

    typedef enum logic [1:0] {FP32, FP16, FP8, FP16ALT} fp_format_e;

    function automatic int unsigned fp_width(input fp_format_e fmt);
        case (fmt)
            FP32:    return 32;
            FP8:     return 8;
            default: return 16;
        endcase
    endfunction

    localparam int unsigned ARRAY_HEIGHT = 3;
    localparam int unsigned ARRAY_WIDTH  = 8;
    localparam int unsigned X_DW         = 288;
    localparam int unsigned X_BITW       = fp_width(FP16);
    localparam int unsigned X_TOT_DEPTH  = ARRAY_HEIGHT * (X_DW / (ARRAY_HEIGHT * X_BITW));
    localparam int unsigned X_ROWS_W     = $clog2(ARRAY_WIDTH) + 1;
    localparam int unsigned X_COLS_W     = $clog2(X_TOT_DEPTH) + 1;
    localparam int unsigned X_TILES_W    = 16;

    typedef enum logic [1:0] {IDLE, FILL, WAIT_FULL, WAIT_EMPTY} x_loader_state_e;

    // Job configuration captured on the start pulse.
    typedef struct packed {
        logic [X_ROWS_W-1:0]  rows_lftovr;
        logic [X_COLS_W-1:0]  cols_lftovr;
        logic [X_TILES_W-1:0] n_tiles;
    } x_loader_cfg_t;

endpackage

// File: rtl/redmule_x_col_mask.sv
// Combinational per-element zero mask: elements at index >= cols_i are cleared,
// cols_i == 0 passes the whole row.
module redmule_x_col_mask #(
    parameter int unsigned DW     = 288,
    parameter int unsigned BITW   = 16,
    parameter int unsigned COLS_W = 6
) (
    input  logic [DW-1:0]     data_i,
    input  logic [COLS_W-1:0] cols_i,
    output logic [DW-1:0]     data_o
);

    localparam int unsigned N_ELEM = DW / BITW;

    always_comb begin
        data_o = data_i;
        for (int unsigned e = 0; e < N_ELEM; e++) begin
            if ((cols_i != '0) && (COLS_W'(e) >= cols_i)) begin
                data_o[e*BITW +: BITW] = '0;
            end
        end
    end

endmodule

// File: rtl/redmule_x_loader.sv
// RedMulE X-operand loader: accepts streamer rows, masks leftover columns and loads the X buffer
// tile by tile. Optional perf counters: `define REDMULE_X_LOADER_PERF_EN.
module redmule_x_loader
    import redmule_pkg::*;
#(
    parameter int unsigned  DW        = 288,
    parameter fp_format_e   FpFormat  = FP16,
    parameter int unsigned  Height    = ARRAY_HEIGHT,
    parameter int unsigned  Width     = ARRAY_WIDTH,
    localparam int unsigned BITW      = fp_width(FpFormat),
    localparam int unsigned D         = DW / (Height * BITW),
    localparam int unsigned TOT_DEPTH = Height * D,
    localparam int unsigned ROWS_W    = $clog2(Width) + 1,
    localparam int unsigned COLS_W    = $clog2(TOT_DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              cfg_valid_i,
    input  logic [ROWS_W-1:0] cfg_rows_lftovr_i,
    input  logic [COLS_W-1:0] cfg_cols_lftovr_i,
    input  logic [15:0]       cfg_n_tiles_i,
    input  logic              x_stream_valid_i,
    input  logic [DW-1:0]     x_stream_data_i,
    output logic              x_stream_ready_o,
    output logic              x_load_o,
    output logic [DW-1:0]     x_data_o,
    input  logic              x_full_i,
    input  logic              x_empty_i,
`ifdef REDMULE_X_LOADER_PERF_EN
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       wait_cnt_o,
`endif
    output logic              busy_o,
    output logic              done_o
);

    x_loader_state_e      state_q, state_d;
    x_loader_cfg_t        cfg_q, cfg_d;
    logic [ROWS_W-1:0]    row_cnt_q, row_cnt_d;
    logic [X_TILES_W-1:0] tile_cnt_q, tile_cnt_d;
    logic                 load_q, load_d;
    logic [DW-1:0]        data_q, data_d;
    logic                 done_q, done_d;

    logic [ROWS_W-1:0]    rows_lftovr;
    logic [ROWS_W-1:0]    row_lim;
    logic [COLS_W-1:0]    cols_lftovr;
    logic                 last_tile;
    logic                 accept;
    logic                 cfg_accept;
    logic [DW-1:0]        masked_data;

    assign rows_lftovr = ROWS_W'(cfg_q.rows_lftovr);
    assign cols_lftovr = COLS_W'(cfg_q.cols_lftovr);
    assign last_tile   = (tile_cnt_q == (cfg_q.n_tiles - X_TILES_W'(1)));
    assign row_lim     = (last_tile && (rows_lftovr != '0)) ? rows_lftovr : ROWS_W'(Width);

    // Ready falls in the same cycle the row count hits the tile limit.
    assign x_stream_ready_o = (state_q == FILL) && (row_cnt_q < row_lim);
    assign accept           = x_stream_ready_o && x_stream_valid_i;
    assign cfg_accept       = (state_q == IDLE) && cfg_valid_i;

    redmule_x_col_mask #(
        .DW     (DW),
        .BITW   (BITW),
        .COLS_W (COLS_W)
    ) i_col_mask (
        .data_i (x_stream_data_i),
        .cols_i (cols_lftovr),
        .data_o (masked_data)
    );

    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        row_cnt_d  = row_cnt_q;
        tile_cnt_d = tile_cnt_q;
        load_d     = accept;
        data_d     = accept ? masked_data : data_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_valid_i) begin
                    cfg_d.rows_lftovr = X_ROWS_W'(cfg_rows_lftovr_i);
                    cfg_d.cols_lftovr = X_COLS_W'(cfg_cols_lftovr_i);
                    cfg_d.n_tiles     = cfg_n_tiles_i;
                    row_cnt_d         = '0;
                    tile_cnt_d        = '0;
                    if (cfg_n_tiles_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                if (accept) begin
                    row_cnt_d = row_cnt_q + ROWS_W'(1);
                    if (row_cnt_d == row_lim) begin
                        state_d = WAIT_FULL;
                    end
                end
            end
            // Full has priority; empty is only looked at once in WAIT_EMPTY.
            WAIT_FULL: begin
                if (x_full_i) begin
                    tile_cnt_d = tile_cnt_q + X_TILES_W'(1);
                    if (tile_cnt_d == cfg_q.n_tiles) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_EMPTY;
                    end
                end
            end
            WAIT_EMPTY: begin
                if (x_empty_i) begin
                    state_d   = FILL;
                    row_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q    <= IDLE;
            cfg_q      <= '0;
            row_cnt_q  <= '0;
            tile_cnt_q <= '0;
            load_q     <= 1'b0;
            data_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            row_cnt_q  <= row_cnt_d;
            tile_cnt_q <= tile_cnt_d;
            load_q     <= load_d;
            data_q     <= data_d;
            done_q     <= done_d;
        end
    end

    assign x_load_o = load_q;
    assign x_data_o = data_q;
    assign done_o   = done_q;
    assign busy_o   = (state_q != IDLE);

`ifdef REDMULE_X_LOADER_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;

    // Saturating stall / wait-for-empty counters, restarted by each accepted job.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        if (cfg_accept) begin
            stall_cnt_d = '0;
            wait_cnt_d  = '0;
        end else begin
            if (x_stream_ready_o && !x_stream_valid_i && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
            if ((state_q == WAIT_EMPTY) && (wait_cnt_q != '1)) begin
                wait_cnt_d = wait_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            stall_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign wait_cnt_o  = wait_cnt_q;
`else
    logic unused_cfg_accept;
    assign unused_cfg_accept = cfg_accept;
`endif

endmodule

// File: tb/tb_redmule_x_loader.sv
// Directed bench for redmule_x_loader (DW=288, FP16, H=3, W=8); a background source streams
// numbered beats and a negedge monitor records accepted beats and loaded rows.
module tb_redmule_x_loader;
    import redmule_pkg::*;

    localparam int unsigned DW     = 288;
    localparam int unsigned W      = 8;
    localparam int unsigned ROWS_W = 4;
    localparam int unsigned COLS_W = 6;
    localparam int unsigned BITW   = 16;
    localparam int unsigned NELEM  = 18;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              clear_i = 1'b0;
    logic              cfg_valid_i = 1'b0;
    logic [ROWS_W-1:0] cfg_rows_lftovr_i = '0;
    logic [COLS_W-1:0] cfg_cols_lftovr_i = '0;
    logic [15:0]       cfg_n_tiles_i = '0;
    logic              x_stream_valid_i = 1'b0;
    logic [DW-1:0]     x_stream_data_i = '0;
    logic              x_stream_ready_o;
    logic              x_load_o;
    logic [DW-1:0]     x_data_o;
    logic              x_full_i = 1'b0;
    logic              x_empty_i = 1'b0;
    logic              busy_o;
    logic              done_o;
`ifdef REDMULE_X_LOADER_PERF_EN
    logic [31:0]       stall_cnt_o;
    logic [31:0]       wait_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    redmule_x_loader #(
        .DW       (DW),
        .FpFormat (FP16),
        .Height   (3),
        .Width    (W)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .clear_i           (clear_i),
        .cfg_valid_i       (cfg_valid_i),
        .cfg_rows_lftovr_i (cfg_rows_lftovr_i),
        .cfg_cols_lftovr_i (cfg_cols_lftovr_i),
        .cfg_n_tiles_i     (cfg_n_tiles_i),
        .x_stream_valid_i  (x_stream_valid_i),
        .x_stream_data_i   (x_stream_data_i),
        .x_stream_ready_o  (x_stream_ready_o),
        .x_load_o          (x_load_o),
        .x_data_o          (x_data_o),
        .x_full_i          (x_full_i),
        .x_empty_i         (x_empty_i),
`ifdef REDMULE_X_LOADER_PERF_EN
        .stall_cnt_o       (stall_cnt_o),
        .wait_cnt_o        (wait_cnt_o),
`endif
        .busy_o            (busy_o),
        .done_o            (done_o)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] acc_q[$];
    logic [DW-1:0] ld_q[$];
    int  lat_err = 0;
    int  done_cnt = 0;
    int  stall_model = 0;
    bit  prev_acc = 1'b0;
    bit  src_acc = 1'b0;

    bit  src_gaps = 1'b0;
    int  src_limit = 0;
    int  issued = 0;
    int unsigned seq = 1;

    function automatic logic [DW-1:0] beat_pattern(input int unsigned s);
        logic [DW-1:0] d;
        logic [15:0]   s16;
        s16 = s[15:0];
        d = '0;
        for (int i = 0; i < 9; i++) d[i*32 +: 32] = {s16 + 16'(i), 8'(i), 8'h5A};
        return d;
    endfunction

    function automatic logic [DW-1:0] exp_mask(input logic [DW-1:0] d, input int cols);
        logic [DW-1:0] r;
        r = d;
        if (cols != 0) for (int e = cols; e < NELEM; e++) r[e*BITW +: BITW] = '0;
        return r;
    endfunction

    // Monitor: everything is sampled mid-cycle.
    always @(negedge clk_i) begin
        src_acc = x_stream_valid_i && x_stream_ready_o;
        if (src_acc) acc_q.push_back(x_stream_data_i);
        if (x_load_o === 1'b1) ld_q.push_back(x_data_o);
        if (x_load_o !== prev_acc) lat_err++;
        prev_acc = src_acc;
        if (done_o === 1'b1) done_cnt++;
        if (x_stream_ready_o && !x_stream_valid_i) stall_model++;
    end

    // Source: holds a beat while valid and not taken, then moves to the next numbered beat.
    initial x_stream_data_i = beat_pattern(1);
    always @(posedge clk_i) begin
        #2;
        if (src_acc) begin
            issued++;
            seq++;
            x_stream_data_i = beat_pattern(seq);
        end
        if (!(x_stream_valid_i && !src_acc))
            x_stream_valid_i = (issued < src_limit) && (!src_gaps || ($urandom_range(0, 2) != 0));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic clear_sb;
        acc_q.delete();
        ld_q.delete();
        lat_err  = 0;
        done_cnt = 0;
    endtask

    task automatic start_job(input int rows, input int cols, input int tiles);
        cfg_rows_lftovr_i = ROWS_W'(rows);
        cfg_cols_lftovr_i = COLS_W'(cols);
        cfg_n_tiles_i     = 16'(tiles);
        cfg_valid_i       = 1'b1;
        stall_model       = 0;
        tick(1);
        cfg_valid_i = 1'b0;
    endtask

    task automatic wait_loads(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (ld_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        tick(3);
        n_vec++; if (x_stream_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b exp 0", x_stream_ready_o); end
        n_vec++; if (x_load_o !== 1'b0) begin n_err++; $display("FAIL reset_load got %b exp 0", x_load_o); end
        n_vec++; if (x_data_o !== '0) begin n_err++; $display("FAIL reset_data got %h exp 0", x_data_o); end
        n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy_o); end
        n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", done_o); end
        rst_i = 1'b0;
        tick(2);
        n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL post_reset_busy got %b exp 0", busy_o); end
        clear_sb();
    endtask

    task automatic test_full_tile;
        bit ok;
        int bad;
        clear_sb();
        src_gaps = 1'b0; issued = 0; src_limit = 1000;
        start_job(0, 0, 1);
        wait_loads(W, 100, ok);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL t1_wait_loads got %0d exp %0d", ld_q.size(), W); end
        tick(4);
        n_vec++; if (ld_q.size() != W) begin n_err++; $display("FAIL t1_load_count got %0d exp %0d", ld_q.size(), W); end
        n_vec++; if (acc_q.size() != W) begin n_err++; $display("FAIL t1_accept_count got %0d exp %0d", acc_q.size(), W); end
        n_vec++; if (lat_err != 0) begin n_err++; $display("FAIL t1_latency got %0d errors exp 0", lat_err); end
        n_vec++; if (x_stream_ready_o !== 1'b0) begin n_err++; $display("FAIL t1_ready_after_w got %b exp 0", x_stream_ready_o); end
        n_vec++; if (busy_o !== 1'b1 || done_cnt != 0) begin n_err++; $display("FAIL t1_busy_before_full got busy=%b done=%0d exp 1/0", busy_o, done_cnt); end
        bad = 0;
        for (int i = 0; i < ld_q.size() && i < acc_q.size(); i++) if (ld_q[i] !== exp_mask(acc_q[i], 0)) bad++;
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL t1_data got %0d bad rows exp 0", bad); end
        x_full_i = 1'b1;
        tick(1);
        x_full_i = 1'b0;
        n_vec++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin n_err++; $display("FAIL t1_done got done=%b busy=%b exp 1/0", done_o, busy_o); end
        tick(1);
        n_vec++; if (done_o !== 1'b0 || done_cnt != 1) begin n_err++; $display("FAIL t1_done_pulse got done=%b cnt=%0d exp 0/1", done_o, done_cnt); end
    endtask

    task automatic test_col_mask;
        bit ok;
        logic [DW-1:0] a, l;
        clear_sb();
        src_gaps = 1'b0; src_limit = 1000;
        start_job(0, 5, 1);
        wait_loads(W, 100, ok);
        tick(2);
        n_vec++; if (ld_q.size() != W) begin n_err++; $display("FAIL t2_load_count got %0d exp %0d", ld_q.size(), W); end
        for (int i = 0; i < ld_q.size() && i < acc_q.size(); i++) begin
            a = acc_q[i];
            l = ld_q[i];
            n_vec++; if (l[79:0] !== a[79:0]) begin n_err++; $display("FAIL t2_low_row%0d got %h exp %h", i, l[79:0], a[79:0]); end
            n_vec++; if (l[DW-1:80] !== '0) begin n_err++; $display("FAIL t2_high_row%0d got %h exp 0", i, l[DW-1:80]); end
        end
        x_full_i = 1'b1;
        tick(1);
        x_full_i = 1'b0;
        n_vec++; if (done_o !== 1'b1) begin n_err++; $display("FAIL t2_done got %b exp 1", done_o); end
        tick(1);
    endtask

    task automatic test_multi_tile;
        bit ok;
        int bad;
        clear_sb();
        src_gaps = 1'b0; src_limit = 1000;
        start_job(2, 0, 3);
        wait_loads(W, 100, ok);
        tick(2);
        n_vec++; if (ld_q.size() != W) begin n_err++; $display("FAIL t3_tile1_loads got %0d exp %0d", ld_q.size(), W); end
        x_full_i = 1'b1;
        tick(1);
        x_full_i = 1'b0;
        // a start pulse while busy must be ignored
        cfg_n_tiles_i = 16'd0;
        cfg_valid_i   = 1'b1;
        tick(1);
        cfg_valid_i = 1'b0;
        tick(4);
        n_vec++; if (acc_q.size() != W) begin n_err++; $display("FAIL t3_hold_before_empty got %0d beats exp %0d", acc_q.size(), W); end
        n_vec++; if (x_stream_ready_o !== 1'b0 || busy_o !== 1'b1 || done_cnt != 0) begin n_err++; $display("FAIL t3_wait_empty got ready=%b busy=%b done=%0d exp 0/1/0", x_stream_ready_o, busy_o, done_cnt); end
        x_empty_i = 1'b1;
        tick(1);
        x_empty_i = 1'b0;
        wait_loads(2*W, 100, ok);
        tick(2);
        n_vec++; if (ld_q.size() != 2*W) begin n_err++; $display("FAIL t3_tile2_loads got %0d exp %0d", ld_q.size(), 2*W); end
        x_full_i  = 1'b1;
        x_empty_i = 1'b1;
        tick(1);
        x_full_i = 1'b0;
        tick(1);
        x_empty_i = 1'b0;
        wait_loads(2*W + 2, 100, ok);
        tick(4);
        n_vec++; if (ld_q.size() != 2*W + 2) begin n_err++; $display("FAIL t3_tile3_loads got %0d exp %0d", ld_q.size(), 2*W + 2); end
        n_vec++; if (acc_q.size() != 2*W + 2 || x_stream_ready_o !== 1'b0) begin n_err++; $display("FAIL t3_tile3_accepts got %0d ready=%b exp %0d/0", acc_q.size(), x_stream_ready_o, 2*W + 2); end
        bad = 0;
        for (int i = 0; i < ld_q.size() && i < acc_q.size(); i++) if (ld_q[i] !== exp_mask(acc_q[i], 0)) bad++;
        n_vec++; if (bad != 0 || lat_err != 0) begin n_err++; $display("FAIL t3_data got %0d bad rows, %0d latency errors exp 0/0", bad, lat_err); end
        x_full_i = 1'b1;
        tick(1);
        x_full_i = 1'b0;
        tick(2);
        n_vec++; if (done_cnt != 1 || busy_o !== 1'b0) begin n_err++; $display("FAIL t3_done got cnt=%0d busy=%b exp 1/0", done_cnt, busy_o); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int bad;
        int rdy_bad;
        clear_sb();
        src_gaps = 1'b1; src_limit = 1000;
        start_job(0, 0, 2);
        wait_loads(W, 300, ok);
        tick(2);
        n_vec++; if (ld_q.size() != W) begin n_err++; $display("FAIL t4_tile1_loads got %0d exp %0d", ld_q.size(), W); end
        x_full_i = 1'b1;
        tick(1);
        x_full_i = 1'b0;
        rdy_bad = 0;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk_i);
            if (x_stream_ready_o !== 1'b0) rdy_bad++;
            tick(1);
        end
        x_empty_i = 1'b1;
        @(negedge clk_i);
        if (x_stream_ready_o !== 1'b0) rdy_bad++;
        tick(1);
        x_empty_i = 1'b0;
        n_vec++; if (rdy_bad != 0 || acc_q.size() != W) begin n_err++; $display("FAIL t4_wait_empty got ready_hi=%0d beats=%0d exp 0/%0d", rdy_bad, acc_q.size(), W); end
        wait_loads(2*W, 300, ok);
        tick(3);
        n_vec++; if (ld_q.size() != 2*W || acc_q.size() != 2*W) begin n_err++; $display("FAIL t4_counts got loads=%0d beats=%0d exp %0d", ld_q.size(), acc_q.size(), 2*W); end
        bad = 0;
        for (int i = 0; i < ld_q.size() && i < acc_q.size(); i++) if (ld_q[i] !== exp_mask(acc_q[i], 0)) bad++;
        n_vec++; if (bad != 0 || lat_err != 0) begin n_err++; $display("FAIL t4_data got %0d bad rows, %0d latency errors exp 0/0", bad, lat_err); end
`ifdef REDMULE_X_LOADER_PERF_EN
        n_vec++; if (wait_cnt_o !== 32'd20) begin n_err++; $display("FAIL t4_wait_cnt got %0d exp 20", wait_cnt_o); end
        n_vec++; if (stall_cnt_o !== 32'(stall_model)) begin n_err++; $display("FAIL t4_stall_cnt got %0d exp %0d", stall_cnt_o, stall_model); end
`endif
        x_full_i = 1'b1;
        tick(1);
        x_full_i = 1'b0;
        n_vec++; if (done_o !== 1'b1) begin n_err++; $display("FAIL t4_done got %b exp 1", done_o); end
        tick(1);
        src_gaps = 1'b0;
    endtask

    task automatic test_clear;
        bit ok;
        clear_sb();
        src_gaps = 1'b0; issued = 0; src_limit = 3;
        start_job(0, 0, 1);
        for (int i = 0; i < 50 && acc_q.size() < 3; i++) tick(1);
        tick(3);
        n_vec++; if (acc_q.size() != 3) begin n_err++; $display("FAIL t5_partial_beats got %0d exp 3", acc_q.size()); end
        clear_i = 1'b1;
        tick(1);
        clear_i = 1'b0;
        n_vec++; if (busy_o !== 1'b0 || x_stream_ready_o !== 1'b0 || x_load_o !== 1'b0) begin n_err++; $display("FAIL t5_after_clear got busy=%b ready=%b load=%b exp 0/0/0", busy_o, x_stream_ready_o, x_load_o); end
        tick(3);
        n_vec++; if (done_cnt != 0 || ld_q.size() != 3) begin n_err++; $display("FAIL t5_no_done got done=%0d loads=%0d exp 0/3", done_cnt, ld_q.size()); end
        clear_sb();
        issued = 0; src_limit = 1000;
        start_job(0, 0, 1);
        wait_loads(W, 100, ok);
        tick(3);
        n_vec++; if (ld_q.size() != W || acc_q.size() != W) begin n_err++; $display("FAIL t5_restart got loads=%0d beats=%0d exp %0d", ld_q.size(), acc_q.size(), W); end
        x_full_i = 1'b1;
        tick(1);
        x_full_i = 1'b0;
        n_vec++; if (done_o !== 1'b1) begin n_err++; $display("FAIL t5_restart_done got %b exp 1", done_o); end
        tick(1);
    endtask

    task automatic test_zero_tiles;
        clear_sb();
        src_limit = 1000;
        start_job(0, 0, 0);
        n_vec++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin n_err++; $display("FAIL t6_done got done=%b busy=%b exp 1/0", done_o, busy_o); end
        tick(1);
        n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL t6_done_pulse got %b exp 0", done_o); end
        tick(3);
        n_vec++; if (acc_q.size() != 0 || ld_q.size() != 0 || done_cnt != 1) begin n_err++; $display("FAIL t6_no_traffic got beats=%0d loads=%0d done=%0d exp 0/0/1", acc_q.size(), ld_q.size(), done_cnt); end
    endtask

    initial begin
        #1;
        test_reset();
        test_full_tile();
        test_col_mask();
        test_multi_tile();
        test_back_to_back();
        test_clear();
        test_zero_tiles();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
